// File: rtl/user_project_wrapper_lwe.sv
// user_project_wrapper_lwe: LWE ciphertext coprocessor in the user slot.
// Wishbone-mapped instruction register, 256-word memory, vector engine.
module user_project_wrapper_lwe #(
    parameter int          PLAINTEXT_MODULUS  = 64,
    parameter int          PLAINTEXT_WIDTH    = 16,
    parameter int          CIPHERTEXT_MODULUS = 1024,
    parameter int          CIPHERTEXT_WIDTH   = 32,
    parameter int          DIMENSION          = 2,
    parameter int          BIG_N              = 3,
    parameter logic [31:0] OUTPUT_ADDR        = 32'h1000_0000,
    parameter int          DATA_WIDTH         = 128,
    parameter logic [31:0] OPCODE_ADDR        = 32'h3000_0000,
    parameter int          ADDR_WIDTH         = 9,
    parameter int          DEPTH              = 256,
    parameter int          DIM_WIDTH          = 8
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oenb,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    inout  wire  [28:0]  analog_io,
    input  logic         user_clock2,
    output logic [2:0]   user_irq
);

    localparam int L  = DIMENSION + 1;
    localparam int NR = 2 * DIMENSION + 1;
    localparam int CW = CIPHERTEXT_WIDTH;
    localparam int PW = 2 * CIPHERTEXT_WIDTH;
    localparam int MB = $clog2(DEPTH);
    localparam int PB = $clog2(PLAINTEXT_MODULUS);
    localparam int IW = 2 + 3 * ADDR_WIDTH;

    localparam logic [PW-1:0] QMASK = PW'(CIPHERTEXT_MODULUS - 1);
    localparam logic [CW-1:0] EMASK = CW'(CIPHERTEXT_MODULUS - 1);
    localparam logic [PW-1:0] SCALE =
        PW'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);

    localparam logic [1:0] OP_ENC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic                 rst;
    logic                 busy;
    logic                 eng_we;
    logic                 done;
    logic [IW-1:0]        instr_q;
    logic [1:0]           op;
    logic [DIM_WIDTH-1:0] cnt;
    logic [DIM_WIDTH-1:0] n_wr;
    logic [MB-1:0]        idx_a;
    logic [MB-1:0]        idx_b;
    logic [MB-1:0]        idx_d;
    logic [CW-1:0]        wr_data;

    logic [CW-1:0] mem   [DEPTH];
    logic [CW-1:0] a_q   [L];
    logic [CW-1:0] b_q   [L];
    logic [CW-1:0] res_q [NR];
    logic [PW-1:0] acc   [NR];

    logic [31:0]   wb_off;
    logic [29:0]   wb_word;
    logic          wb_req;
    logic          wb_hit_ir;
    logic          wb_hit_mem;
    logic          wb_wr;
    logic          wb_mem_we;
    logic          start;
    logic [MB-1:0] wb_idx;
    logic [31:0]   rd_data;
    logic          unused_ok;

    assign rst = la_oenb[1] ? wb_rst_i : la_data_in[1];

    assign la_data_out = '0;
    assign io_out      = '0;
    assign io_oeb      = '1;
    assign user_irq    = {2'b00, done};

    assign unused_ok = ^{wbs_sel_i, la_data_in[127:2], la_data_in[0],
                         la_oenb[127:2], la_oenb[0], io_in, analog_io,
                         user_clock2, wb_off[1:0], BIG_N[0],
                         OUTPUT_ADDR[0], DATA_WIDTH[0],
                         PLAINTEXT_WIDTH[0]};

    assign wb_off     = wbs_adr_i - OPCODE_ADDR;
    assign wb_word    = wb_off[31:2];
    assign wb_req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wb_wr      = wb_req & wbs_we_i;
    assign wb_hit_ir  = (wb_word == 30'd0);
    assign wb_hit_mem = (wb_word != 30'd0) && (wb_word <= 30'(DEPTH));
    assign wb_idx     = MB'(wb_word - 30'd1);
    assign wb_mem_we  = wb_wr & wb_hit_mem & ~busy & ~rst;
    assign start      = wb_wr & wb_hit_ir & wbs_dat_i[31] & ~busy;

    assign op    = instr_q[1:0];
    assign idx_a = instr_q[2 +: MB] + MB'(cnt);
    assign idx_b = instr_q[2 + ADDR_WIDTH +: MB] + MB'(cnt);
    assign idx_d = instr_q[2 + 2 * ADDR_WIDTH +: MB] + MB'(cnt);

    // Read mux for the Wishbone data path
    always_comb begin
        rd_data = '0;
        if (wb_hit_ir) begin
            rd_data = {busy, {(31 - IW){1'b0}}, instr_q};
        end else if (wb_hit_mem) begin
            rd_data = mem[wb_idx];
        end
    end

    // Ack pulse and registered read data
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            if (wb_req && !wbs_we_i) begin
                wbs_dat_o <= rd_data;
            end
        end
    end

    // Instruction latch on an accepted start
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if (start) begin
            instr_q <= wbs_dat_i[IW-1:0];
        end
    end

    // Operand memory; engine write-back and host writes never overlap
    always_ff @(posedge wb_clk_i) begin
        if (eng_we) begin
            mem[idx_d] <= wr_data;
        end else if (wb_mem_we) begin
            mem[wb_idx] <= wbs_dat_i;
        end
    end

    // Number of result words each opcode writes back
    always_comb begin
        n_wr = DIM_WIDTH'(L);
        unique case (op)
            OP_ENC: n_wr = DIM_WIDTH'(L);
            OP_DEC: n_wr = DIM_WIDTH'(1);
            OP_ADD: n_wr = DIM_WIDTH'(L);
            OP_MUL: n_wr = DIM_WIDTH'(NR);
        endcase
    end

    // Engine state register
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Engine next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (cnt == DIM_WIDTH'(L - 1)) state_nx = S_CALC;
            end
            S_CALC: begin
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (cnt == n_wr - DIM_WIDTH'(1)) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Engine status outputs decoded from the state
    always_comb begin
        busy   = (state != S_IDLE);
        eng_we = (state == S_WRITE);
        done   = (state == S_DONE);
    end

    // All result words computed in parallel from the loaded vectors
    always_comb begin
        for (int k = 0; k < NR; k++) begin
            acc[k] = '0;
        end
        unique case (op)
            OP_ADD: begin
                for (int i = 0; i < L; i++) begin
                    acc[i] = PW'(a_q[i]) + PW'(b_q[i]);
                end
            end
            OP_MUL: begin
                for (int i = 0; i < L; i++) begin
                    for (int j = 0; j < L; j++) begin
                        acc[i+j] = acc[i+j] + PW'(a_q[i]) * PW'(b_q[j]);
                    end
                end
            end
            OP_DEC: begin
                for (int i = 0; i < L; i++) begin
                    acc[0] = acc[0] + PW'(a_q[i]) * PW'(b_q[i]);
                end
            end
            OP_ENC: begin
                for (int i = 0; i < L; i++) begin
                    acc[i] = PW'(b_q[i]);
                end
                acc[L-1] = acc[L-1] + PW'(a_q[0][PB-1:0]) * SCALE;
            end
        endcase
    end

    // Select the result word for the current write-back slot
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < NR; k++) begin
            if (cnt == DIM_WIDTH'(k)) wr_data = res_q[k];
        end
    end

    // Engine counter, operand load and result capture
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < L; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int k = 0; k < NR; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    for (int i = 0; i < L; i++) begin
                        if (cnt == DIM_WIDTH'(i)) begin
                            a_q[i] <= mem[idx_a] & EMASK;
                            b_q[i] <= mem[idx_b] & EMASK;
                        end
                    end
                    if (cnt == DIM_WIDTH'(L - 1)) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + DIM_WIDTH'(1);
                    end
                end
                S_CALC: begin
                    for (int k = 0; k < NR; k++) begin
                        res_q[k] <= CW'(acc[k] & QMASK);
                    end
                    cnt <= '0;
                end
                S_WRITE: begin
                    cnt <= cnt + DIM_WIDTH'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_project_wrapper_lwe.sv
// tb_user_project_wrapper_lwe: randomized self-checking bench for the
// LWE coprocessor against a behavioural vector model.
`timescale 1ns/1ps
module tb_user_project_wrapper_lwe;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int Q = 1024;
    localparam int P = 64;
    localparam int N = 2;
    localparam int OP_ENC = 0;
    localparam int OP_DEC = 1;
    localparam int OP_ADD = 2;
    localparam int OP_MUL = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stb;
    logic         cyc;
    logic         we;
    logic [3:0]   sel;
    logic [31:0]  adr;
    logic [31:0]  wdat;
    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb = '1;
    logic [127:0] la_data_out;
    logic [37:0]  io_in;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    wire  [28:0]  analog_io;
    logic         user_clock2;
    logic [2:0]   irq;

    int vectors = 0;
    int miscompares = 0;
    int irq_cnt = 0;
    int ops_expected = 0;
    int unsigned model_mem [256];

    user_project_wrapper_lwe dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (wdat),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .la_data_in (la_data_in),
        .la_data_out(la_data_out),
        .la_oenb    (la_oenb),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .analog_io  (analog_io),
        .user_clock2(user_clock2),
        .user_irq   (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq[0]) irq_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] mem_addr(input int i);
        return BASE + 32'(4 * (i + 1));
    endfunction

    function automatic logic [31:0] instr(input int op, input int a,
                                          input int b, input int d);
        logic [8:0] fa, fb, fd;
        logic [1:0] fo;
        fa = 9'(a);
        fb = 9'(b);
        fd = 9'(d);
        fo = 2'(op);
        return {1'b1, 2'b00, fd, fb, fa, fo};
    endfunction

    function automatic int model_op(input int op, input int a, input int b,
                                    input int d);
        int unsigned av [3];
        int unsigned bv [3];
        int unsigned r [5];
        int nw;
        for (int i = 0; i < 3; i++) begin
            av[i] = model_mem[(a + i) % 256] % Q;
            bv[i] = model_mem[(b + i) % 256] % Q;
        end
        for (int k = 0; k < 5; k++) r[k] = 0;
        nw = 0;
        case (op)
            OP_ADD: begin
                for (int i = 0; i < 3; i++) r[i] = av[i] + bv[i];
                nw = 3;
            end
            OP_MUL: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        r[i+j] += av[i] * bv[j];
                nw = 5;
            end
            OP_DEC: begin
                for (int i = 0; i < 3; i++) r[0] += av[i] * bv[i];
                nw = 1;
            end
            default: begin
                for (int i = 0; i < 3; i++) r[i] = bv[i];
                r[N] += ((model_mem[a % 256] & 32'hffff) % P) * (Q / P);
                nw = 3;
            end
        endcase
        for (int k = 0; k < nw; k++) model_mem[(d + k) % 256] = r[k] % Q;
        return nw;
    endfunction

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        adr = a; wdat = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 10);
        if (!ack) check("wb_write_ack_timeout", 32'(ack), 1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 10);
        if (!ack) check("wb_read_ack_timeout", 32'(ack), 1);
        d = rdat;
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic set_mem(input int i, input logic [31:0] v);
        wb_write(mem_addr(i), v);
        model_mem[i] = v;
    endtask

    task automatic chk_mem(input string tag, input int i,
                           input logic [31:0] exp);
        logic [31:0] v;
        wb_read(mem_addr(i % 256), v);
        check(tag, v, exp);
    endtask

    task automatic run_op(input int op, input int a, input int b,
                          input int d, output int nw);
        int n;
        wb_write(BASE, instr(op, a, b, d));
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!irq[0] && n < 30);
        check("done_latency_le_12", 32'(irq[0] && n <= 12), 1);
        @(posedge clk); #1;
        check("irq_one_cycle", 32'(irq[0]), 0);
        nw = model_op(op, a, b, d);
        ops_expected++;
    endtask

    task automatic op_verify(input string tag, input int op, input int a,
                             input int b, input int d);
        int nw;
        run_op(op, a, b, d, nw);
        for (int k = 0; k < nw; k++) begin
            chk_mem(tag, (d + k) % 256, model_mem[(d + k) % 256]);
        end
    endtask

    initial begin
        logic [31:0] v;
        int n, snap, cnt;
        stb = 0; cyc = 0; we = 0; sel = 4'hf; adr = '0; wdat = '0;
        io_in = '0; user_clock2 = 0; la_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack), 0);
        check("reset_dat", rdat, 0);
        check("reset_irq", 32'(irq), 0);
        check("io_oeb_ones", 32'(&io_oeb), 1);
        check("io_out_zero", 32'(|io_out), 0);
        check("la_out_zero", 32'(|la_data_out), 0);
        @(negedge clk) rst = 1'b0;
        wb_read(BASE, v);
        check("reset_instr_reg", v, 0);

        for (int i = 0; i < 256; i++) set_mem(i, $urandom());
        for (int i = 0; i < 6; i++) begin
            set_mem(i, 32'(10 + i));
            set_mem(100 + i, 32'(20 + i));
        end
        chk_mem("readback_mem3", 3, 13);

        cnt = 0;
        @(negedge clk);
        adr = mem_addr(3); we = 0; stb = 1; cyc = 1;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) cnt++;
        end
        stb = 0; cyc = 0;
        check("ack_every_other_cycle", 32'(cnt), 2);
        check("held_read_data", rdat, 13);

        op_verify("add_model", OP_ADD, 0, 100, 50);
        chk_mem("add_50", 50, 30);
        chk_mem("add_51", 51, 32);
        chk_mem("add_52", 52, 34);
        set_mem(200, $urandom());
        check("dat_hold_after_write", rdat, 34);

        op_verify("dec_model", OP_DEC, 0, 100, 30);
        chk_mem("dec_30", 30, 695);

        op_verify("mul_model", OP_MUL, 0, 100, 40);
        chk_mem("mul_40", 40, 200);
        chk_mem("mul_41", 41, 430);
        chk_mem("mul_42", 42, 691);
        chk_mem("mul_43", 43, 494);
        chk_mem("mul_44", 44, 264);

        op_verify("enc_model", OP_ENC, 0, 100, 70);
        chk_mem("enc_70", 70, 20);
        chk_mem("enc_71", 71, 21);
        chk_mem("enc_72", 72, 182);
        set_mem(0, 70);
        op_verify("enc2_model", OP_ENC, 0, 100, 70);
        chk_mem("enc2_72", 72, 118);

        snap = irq_cnt;
        wb_write(BASE, instr(OP_ADD, 0, 100, 60));
        wb_write(BASE, instr(OP_MUL, 0, 100, 80));
        wb_write(mem_addr(120), 32'hdead_beef);
        wb_read(BASE, v);
        check("busy_bit_set", 32'(v[31]), 1);
        check("busy_instr_kept", 32'(v[28:0]),
              32'(instr(OP_ADD, 0, 100, 60) & 32'h1fff_ffff));
        n = 0;
        while (irq_cnt == snap && n < 30) begin
            @(posedge clk); #1; n++;
        end
        check("busy_op_done", 32'(irq_cnt != snap), 1);
        void'(model_op(OP_ADD, 0, 100, 60));
        ops_expected++;
        wb_read(BASE, v);
        check("busy_bit_clear", 32'(v[31]), 0);
        for (int k = 0; k < 3; k++) chk_mem("busy_add", 60 + k, model_mem[60 + k]);
        for (int k = 0; k < 5; k++) chk_mem("ignored_start", 80 + k, model_mem[80 + k]);
        chk_mem("busy_write_dropped", 120, model_mem[120]);

        wb_write(BASE, instr(OP_MUL, 0, 100, 90));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midop_reset_ack", 32'(ack), 0);
        check("midop_reset_irq", 32'(irq), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wb_read(BASE, v);
        check("midop_reset_busy_instr", v, 0);
        for (int k = 0; k < 5; k++) chk_mem("aborted_mul", 90 + k, model_mem[90 + k]);

        op_verify("la_pre_add", OP_ADD, 3, 102, 150);
        wb_read(BASE, v);
        check("instr_after_op", v, instr(OP_ADD, 3, 102, 150) & 32'h1fff_ffff);
        la_oenb[1] = 1'b0;
        la_data_in[1] = 1'b1;
        #2;
        check("la_reset_ack", 32'(ack), 0);
        @(negedge clk);
        la_data_in[1] = 1'b0;
        la_oenb[1] = 1'b1;
        wb_read(BASE, v);
        check("la_reset_instr", v, 0);

        op_verify("wrap_add", OP_ADD, 0, 100, 255);

        wb_write(BASE + 32'(4 * 257), 32'h1234_5678);
        wb_read(BASE + 32'(4 * 257), v);
        check("oor_read_257", v, 0);
        wb_read(BASE - 32'd4, v);
        check("oor_read_below", v, 0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1)
                set_mem($urandom_range(0, 255), $urandom());
            op_verify("rand_op", $urandom_range(0, 3), $urandom_range(0, 511),
                      $urandom_range(0, 511), $urandom_range(0, 511));
        end

        for (int i = 0; i < 256; i++) chk_mem("final_scan", i, model_mem[i]);
        check("irq_pulse_count", 32'(irq_cnt), 32'(ops_expected));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/user_project_wrapper_lwe.md
# user_project_wrapper_lwe

LWE-style ciphertext coprocessor placed in the user-project slot of the SoC. A Wishbone slave exposes a 256-word operand/result memory and an instruction register. An internal engine performs add, multiply (polynomial convolution), decrypt (inner product) and encrypt on (DIMENSION+1)-element vectors, with all arithmetic modulo CIPHERTEXT_MODULUS.

## Interface
- PLAINTEXT_MODULUS, 64: p, a power of two; encrypt reduces the message mod p.
- PLAINTEXT_WIDTH, 16: number of low bits of the message word used by encrypt.
- CIPHERTEXT_MODULUS, 1024: q, a power of two; every result element is reduced mod q.
- CIPHERTEXT_WIDTH, 32: stored element width.
- DIMENSION, 2: n; a vector is L = n+1 elements.
- BIG_N, 3; OUTPUT_ADDR, 32'h10000000; DATA_WIDTH, 128: reserved, no functional effect.
- OPCODE_ADDR, 32'h30000000: Wishbone base address; the instruction register sits here.
- ADDR_WIDTH, 9: width of each instruction address field.
- DEPTH, 256: number of memory words.
- DIM_WIDTH, 8: width of the engine index counters.
- wb_clk_i  in  1  the only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high. Effective reset = la_oenb[1] ? wb_rst_i : la_data_in[1].
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
- wbs_ack_o  out  1;  wbs_dat_o  out  32  read data.
- la_data_in, la_oenb  in  128 each;  la_data_out  out  128, driven 0.
- io_in  in  38;  io_out  out  38, driven 0;  io_oeb  out  38, driven all 1s.
- analog_io  inout  29, unconnected;  user_clock2  in  1, unused.
- user_irq  out  3. Bit 0 is a one-cycle done pulse; bits 2:1 are 0.

## Operation
- Word offset w = (wbs_adr_i − OPCODE_ADDR) >> 2.
  - w = 0: instruction register.
  - w = 1..256: mem[w−1].
  - Any other address: acknowledged, writes dropped, reads return 0.
- Instruction word fields:
  - [1:0] op: 00 encrypt, 01 decrypt, 10 add, 11 multiply.
  - [10:2] A, [19:11] B, [28:20] D (operand and destination addresses).
  - [31] start.
- A write to w = 0 with bit 31 set, while idle, latches the instruction and starts the engine.
- A start written while busy is ignored.
- Reading w = 0 returns {busy, 2'b0, latched bits [28:0]}.
- Element addresses are taken modulo DEPTH: the i-th element of A is mem[(A+i) mod 256].
- Operands are reduced mod q before use; results are written mod q.
- Operations, with a_i = mem[A+i] and b_i = mem[B+i]:
  - add: mem[D+i] = a_i + b_i, for i = 0..n.
  - multiply: mem[D+k] = sum over i+j=k of a_i·b_j, for k = 0..2n. This writes 2n+1 words.
  - decrypt: mem[D] = sum over i = 0..n of a_i·b_i. The b vector is the key, supplied by software.
  - encrypt: m = mem[A][PLAINTEXT_WIDTH−1:0] mod p.
    - mem[D+i] = b_i for i < n.
    - mem[D+n] = b_n + m·(q/p).
- Wishbone writes to memory while busy are dropped but still acknowledged. Wishbone reads are always served.
- Each engine write-back occurs in its own cycle.

## Timing
- Reset values:
  - wbs_ack_o = 0, wbs_dat_o = 0, busy = 0, user_irq = 0, instruction register = 0.
  - Memory contents are not reset.
- Wishbone handshake:
  - wbs_ack_o rises one cycle after stb&cyc are sampled high with ack low.
  - ack stays high exactly one cycle and then drops for at least one cycle, so a strobe held high produces a new ack every other cycle.
  - Writes take effect on the ack edge.
  - wbs_dat_o is registered with ack and holds its value until the next read ack.
- Engine FSM, one state per cycle unless stated:
  - IDLE → LOAD: copy L elements of A and L of B into local registers, one pair per cycle.
  - LOAD → CALC: one cycle, all products computed in parallel.
  - CALC → WRITE: one result word per cycle.
  - WRITE → DONE: pulse user_irq[0]; go to IDLE.
- busy is high from the cycle after the start write until the DONE cycle.
- Latency is at most 12 cycles for every op with n = 2.
- Reset asserted mid-operation aborts immediately. Words already written back remain.
- Products use 2·CIPHERTEXT_WIDTH-bit intermediates. Reduction is a mask to log2(q) bits.

## Test plan
- Setup: mem[0..5] = 10..15 and mem[100..105] = 20..25 via Wishbone. Read back mem[3] → 13.
- Add: A=0, B=100, D=50. After 12 cycles, mem[50..52] read back as 30, 32, 34.
- Decrypt: A=0, B=100, D=30 → mem[30] = 695.
- Multiply: A=0, B=100, D=40 → mem[40..44] = 200, 430, 691, 494, 264.
- Encrypt: A=0, B=100, D=70 → mem[70..72] = 20, 21, 182.
  - Then write mem[0] = 70 and repeat → mem[72] = 118, since m = 6.
- Busy and reset:
  - A second start issued during an add is ignored.
  - Reset asserted at cycle 3 of a multiply leaves busy = 0 and ack = 0.
  - An add with D = 255 wraps its writes to mem[255], mem[0], mem[1].
